// File: rtl/prng_draw_scheduler_if.sv
// Signal bundle between the draw scheduler, its requesters/seed writer and the
// shared 3x+4 generator core. The scheduler sits on the slave side.
interface prng_draw_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 12
);
    localparam int ID_W = $clog2(N_REQ);

    logic             seed_we;
    logic [WIDTH-1:0] seed_in;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             rnd_valid;
    logic [WIDTH-1:0] rnd_data;
    logic [ID_W-1:0]  rnd_id;
    logic             busy;
    logic [15:0]      draw_cnt;
    logic             core_load;
    logic [WIDTH-1:0] core_seed;
    logic             core_step;
    logic [WIDTH-1:0] core_data;

    modport slave (
        input  seed_we, seed_in, req, core_data,
        output gnt, rnd_valid, rnd_data, rnd_id, busy, draw_cnt,
               core_load, core_seed, core_step
    );

    modport master (
        output seed_we, seed_in, req, core_data,
        input  gnt, rnd_valid, rnd_data, rnd_id, busy, draw_cnt,
               core_load, core_seed, core_step
    );
endinterface

// File: rtl/prng_draw_scheduler.sv
// Shares one pseudorandom core among N_REQ requesters: seeds the core, grants
// draws round-robin, steps the core once per grant and returns the tagged value.
module prng_draw_scheduler #(
    parameter int               N_REQ        = 4,
    parameter int               WIDTH        = 12,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 12'h5A5
) (
    input  logic                  clk,
    input  logic                  rst,
    prng_draw_scheduler_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_SEED,
        S_IDLE,
        S_STEP,
        S_CAPTURE
    } state_e;

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_seed;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_winner;
    logic             r_reseed_pend;
    logic             r_rnd_valid;
    logic [WIDTH-1:0] r_rnd_data;
    logic [ID_W-1:0]  r_rnd_id;
    logic [15:0]      r_draw_cnt;

    logic [ID_W-1:0]  w_winner;
    logic             w_any_req;
    logic [N_REQ-1:0] w_gnt;
    logic             w_core_load;
    logic             w_core_step;

    // Round-robin scan: walk from the farthest slot back to rr_ptr so the
    // nearest set request (counting upward with wrap) is the last one written.
    always_comb begin
        w_winner  = r_rr_ptr;
        w_any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req[idx]) begin
                w_winner  = ID_W'(idx);
                w_any_req = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next      = r_state;
        w_gnt       = '0;
        w_core_load = 1'b0;
        w_core_step = 1'b0;
        unique case (r_state)
            S_SEED: begin
                w_core_load = 1'b1;
                w_next      = S_IDLE;
            end
            S_IDLE: begin
                if (r_reseed_pend || bus.seed_we) w_next = S_SEED;
                else if (w_any_req)               w_next = S_STEP;
            end
            S_STEP: begin
                w_gnt[r_winner] = 1'b1;
                w_core_step     = 1'b1;
                w_next          = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_SEED;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_SEED;
            r_seed        <= SEED_DEFAULT;
            r_rr_ptr      <= '0;
            r_winner      <= '0;
            r_reseed_pend <= 1'b0;
            r_rnd_valid   <= 1'b0;
            r_rnd_data    <= '0;
            r_rnd_id      <= '0;
            r_draw_cnt    <= '0;
        end else begin
            r_state     <= w_next;
            r_rnd_valid <= 1'b0;

            if (bus.seed_we) r_seed <= bus.seed_in;

            // A seed write outside IDLE is deferred so an in-flight draw
            // finishes on the old sequence.
            if (r_state == S_IDLE) begin
                r_reseed_pend <= 1'b0;
                r_winner      <= w_winner;
            end else if (bus.seed_we) begin
                r_reseed_pend <= 1'b1;
            end

            if (r_state == S_STEP)
                r_rr_ptr <= (r_winner == LAST_ID) ? '0 : r_winner + 1'b1;

            if (r_state == S_CAPTURE) begin
                r_rnd_data  <= bus.core_data;
                r_rnd_id    <= r_winner;
                r_rnd_valid <= 1'b1;
                r_draw_cnt  <= r_draw_cnt + 16'd1;
            end
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.rnd_valid = r_rnd_valid;
    assign bus.rnd_data  = r_rnd_data;
    assign bus.rnd_id    = r_rnd_id;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.draw_cnt  = r_draw_cnt;
    assign bus.core_load = w_core_load;
    assign bus.core_seed = r_seed;
    assign bus.core_step = w_core_step;
endmodule

// File: doc/prng_draw_scheduler.md
Name: prng_draw_scheduler

Overview:
Controller that shares one 12-bit pseudorandom generator core among N_REQ requesters. It loads and reloads the core seed, arbitrates draw requests round-robin, steps the core once per granted draw and returns the result tagged with the requester id. It sits between the generator core (recurrence next = 3*prev + 4) and the consumer blocks.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 12, generator word width
SEED_DEFAULT, 12'h5A5, seed loaded after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
seed_we  in  1  write seed_in into seed register
seed_in  in  WIDTH  new seed value
req  in  N_REQ  draw request per requester, level, held until gnt
gnt  out  N_REQ  one-hot grant pulse, 1 cycle
rnd_valid  out  1  result pulse, 1 cycle
rnd_data  out  WIDTH  drawn value, valid with rnd_valid
rnd_id  out  $clog2(N_REQ)  requester index of rnd_data
busy  out  1  high when state != IDLE
draw_cnt  out  16  completed draws, wraps 0xFFFF->0
core_load  out  1  core loads core_seed at this edge
core_seed  out  WIDTH  seed to core (= seed register)
core_step  out  1  core advances at this edge
core_data  in  WIDTH  core current value

Behaviour:
- Core contract: at an edge with core_load=1, core_data <= core_seed; with core_step=1, core_data <= (3*core_data + 4) mod 2^WIDTH. The block never asserts both at once.
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=SEED, seed_reg=SEED_DEFAULT, rr_ptr=0, reseed_pend=0, gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, draw_cnt=0. Reset mid-draw aborts it: no gnt, no rnd_valid.
- States:
  - SEED: core_load=1 for 1 cycle, then IDLE.
  - IDLE: checks, in priority order:
    - reseed_pend or seed_we -> SEED, and reseed_pend clears.
    - else any req -> STEP. The winner is the first set req bit scanning from rr_ptr upward, with wrap-around.
    - else stay in IDLE.
  - STEP: gnt[winner]=1 and core_step=1 for this single cycle. rr_ptr <= (winner+1) mod N_REQ. Next state is CAPTURE.
  - CAPTURE: at the edge, rnd_data <= core_data and rnd_id <= winner. rnd_valid is high the following cycle. Next state is IDLE.
- Timing: req seen in IDLE at cycle t -> gnt at t+1 -> rnd_valid at t+3.
  - rnd_valid coincides with the next IDLE cycle, so back-to-back draws occur every 3 cycles.
- req handling:
  - req is sampled only in IDLE; a req dropped before its grant is ignored.
  - A requester holding req after gnt is re-arbitrated and gets another draw.
  - The consumer cannot stall the block: rnd_valid is a 1-cycle pulse with no ready signal.
- seed_we: seed_reg <= seed_in in any state.
  - In IDLE it wins over a simultaneous req. The req is served after the reseed completes and draws from the new seed.
  - In SEED, STEP or CAPTURE, seed_we sets reseed_pend. The reseed happens on the next IDLE, and an in-flight draw completes with the old sequence.
- draw_cnt increments with each rnd_valid.
- busy = (state != IDLE). It is high during the post-reset SEED cycle.

Test Plan:
- Reset, then idle: 1st cycle after rst low -> core_load=1, core_seed=0x5A5. Next cycle -> busy=0, all outputs 0.
- req=4'b0100 held: gnt=4'b0100 one cycle after req; 2 cycles later rnd_valid=1, rnd_data=0x0F3, rnd_id=2, draw_cnt=1. Drop req after gnt -> no further grant.
- req=4'b1111 held after reset: grants in order 0,1,2,3,0 with rnd_data 0x0F3, 0x2DD, 0x89B, 0x9D5, ...; rnd_valid spaced exactly 3 cycles apart.
- seed_we=1, seed_in=0x001 together with req[1] in IDLE: SEED first (core_seed=0x001). Then gnt[1] -> rnd_data=0x007; repeat -> 0x019, 0x04F.
- seed_we=1, seed_in=0x001 during STEP of a draw from 0x5A5: the draw returns 0x0F3. The following IDLE enters SEED. The next draw returns 0x007.
- rst asserted during STEP: no rnd_valid. After reset, seed is 0x5A5 again, rr_ptr=0 and draw_cnt=0.
